// File: rtl/seg7_frame_decoder.sv
// seg7_frame_decoder: watches a multiplexed seven-segment bus and recovers
// the displayed hex frame. Each digit must hold steady before it is decoded.
// Once every digit has been captured, the frame is published with a
// one-cycle frame_valid pulse.
module seg7_frame_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_err,
    output logic                    frame_valid
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic {
        WAIT_STABLE,
        HELD
    } state_t;

    state_t state, state_nxt;

    logic [7:0]              s_seg, p_seg;
    logic [NUM_DIGITS-1:0]   s_an, p_an;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic                    an_onehot;
    logic                    cnt_clr;
    logic                    accept;
    logic [4:0]              dec;
    logic [NUM_DIGITS-1:0]   seen, seen_nxt;
    logic                    frame_done;
    logic [4*NUM_DIGITS-1:0] cap_val;
    logic [NUM_DIGITS-1:0]   cap_dp;
    logic [NUM_DIGITS-1:0]   cap_err;

    // Returns {err, nibble}. An unknown pattern decodes to nibble 0 with err set.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F:   r = 5'h00;
            7'h06:   r = 5'h01;
            7'h5B:   r = 5'h02;
            7'h4F:   r = 5'h03;
            7'h66:   r = 5'h04;
            7'h6D:   r = 5'h05;
            7'h7D:   r = 5'h06;
            7'h07:   r = 5'h07;
            7'h7F:   r = 5'h08;
            7'h6F:   r = 5'h09;
            7'h77:   r = 5'h0A;
            7'h7C:   r = 5'h0B;
            7'h39:   r = 5'h0C;
            7'h5E:   r = 5'h0D;
            7'h79:   r = 5'h0E;
            7'h71:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    // Input sample stage, previous-sample copy for change detection, and stability counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_seg <= '0;
            s_an  <= '0;
            p_seg <= '0;
            p_an  <= '0;
            cnt   <= '0;
        end else begin
            s_seg <= seg;
            s_an  <= an;
            p_seg <= s_seg;
            p_an  <= s_an;
            cnt   <= cnt_nxt;
        end
    end

    // Stability counter next value: clear on change or a non-one-hot select, else saturate
    always_comb begin
        an_onehot = (s_an != '0) && ((s_an & (s_an - NUM_DIGITS'(1))) == '0);
        cnt_clr   = !an_onehot || ({s_seg, s_an} != {p_seg, p_an});
        cnt_nxt   = cnt;
        if (cnt_clr) begin
            cnt_nxt = '0;
        end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= WAIT_STABLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and accept strobe. The accept fires on the edge at which
    // the counter becomes CNT_MAX, so a digit steady from edge n is captured at edge n+STABLE_CYCLES.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            WAIT_STABLE: begin
                if (!cnt_clr && cnt_nxt == CNT_MAX) begin
                    accept    = 1'b1;
                    state_nxt = HELD;
                end
            end
            HELD: begin
                if (cnt_clr) begin
                    state_nxt = WAIT_STABLE;
                end
            end
            default: state_nxt = WAIT_STABLE;
        endcase
    end

    // Decode the current pattern. Compute the seen mask so that an accept
    // landing on the frame-publish edge counts toward the next frame.
    always_comb begin
        dec        = decode(s_seg[6:0]);
        frame_done = &seen;
        seen_nxt   = frame_done ? '0 : seen;
        if (accept) begin
            seen_nxt = seen_nxt | s_an;
        end
    end

    // Per-digit capture slots and frame publication
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen        <= '0;
            cap_val     <= '0;
            cap_dp      <= '0;
            cap_err     <= '0;
            value       <= '0;
            dp_out      <= '0;
            digit_err   <= '0;
            frame_err   <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            seen        <= seen_nxt;
            frame_valid <= frame_done;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (accept && s_an[i]) begin
                    cap_val[4*i +: 4] <= dec[3:0];
                    cap_dp[i]         <= s_seg[7];
                    cap_err[i]        <= dec[4];
                end
            end
            if (frame_done) begin
                value     <= cap_val;
                dp_out    <= cap_dp;
                digit_err <= cap_err;
                frame_err <= |cap_err;
            end
        end
    end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Testbench for seg7_frame_decoder. Expected frames are queued as each sweep
// is driven, then popped and compared whenever frame_valid pulses.
module tb_seg7_frame_decoder;

    logic        clk;
    logic        rst_n;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  dp_out;
    logic [3:0]  digit_err;
    logic        frame_err;
    logic        frame_valid;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  dp;
        logic [3:0]  err;
        logic        ferr;
    } frame_t;

    frame_t exp_q[$];
    frame_t e;
    int     checks  = 0;
    int     errors  = 0;
    int     nframes = 0;
    logic   prev_fv = 1'b0;

    seg7_frame_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .value       (value),
        .dp_out      (dp_out),
        .digit_err   (digit_err),
        .frame_err   (frame_err),
        .frame_valid (frame_valid)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] v, input logic [3:0] dp,
                            input logic [3:0] err);
        frame_t f;
        f.v    = v;
        f.dp   = dp;
        f.err  = err;
        f.ferr = |err;
        exp_q.push_back(f);
    endtask

    // Show pattern p on digit d for cyc clock edges
    task automatic show(input int d, input logic [7:0] p, input int cyc);
        seg = p;
        an  = 4'b0001 << d;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_value"}, value, 0);
        check({tag, "_dp"}, dp_out, 0);
        check({tag, "_derr"}, digit_err, 0);
        check({tag, "_ferr"}, frame_err, 0);
        check({tag, "_fv"}, frame_valid, 0);
    endtask

    // Frame monitor: sample on the falling edge, compare against the scoreboard
    always @(negedge clk) begin
        if (rst_n && frame_valid) begin
            nframes++;
            check("fv_single_cycle", prev_fv, 0);
            check("frame_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("value", value, e.v);
                check("dp_out", dp_out, e.dp);
                check("digit_err", digit_err, e.err);
                check("frame_err", frame_err, e.ferr);
            end
        end
        prev_fv = frame_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        seg   = 8'h00;
        an    = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Basic sweep: 4F,66,06,3F -> 0143
        push_exp(16'h0143, 4'b0000, 4'b0000);
        show(0, 8'h4F, 40);
        show(1, 8'h66, 40);
        show(2, 8'h06, 40);
        show(3, 8'h3F, 40);

        // Decimal point on digit 2
        push_exp(16'h3610, 4'b0100, 4'b0000);
        show(0, 8'h3F, 30);
        show(1, 8'h06, 30);
        show(2, 8'hFD, 30);
        show(3, 8'h4F, 30);

        // Short hold on the last missing digit must not complete the frame
        push_exp(16'h7140, 4'b0000, 4'b0000);
        show(0, 8'h3F, 30);
        show(2, 8'h06, 30);
        show(3, 8'h07, 30);
        show(1, 8'h5B, 10);
        show(1, 8'h66, 30);
        check("short_hold_frames", nframes, 3);

        // Multi-hot select between partial captures must not accept
        push_exp(16'h8765, 4'b0000, 4'b0000);
        show(0, 8'h6D, 30);
        show(3, 8'h7F, 30);
        seg = 8'h3F;
        an  = 4'b0110;
        repeat (50) @(posedge clk);
        #1;
        check("multihot_frames", nframes, 3);
        show(1, 8'h7D, 30);
        show(2, 8'h07, 30);

        // Unmapped pattern on digit 3
        push_exp(16'h0CBA, 4'b0000, 4'b1000);
        show(0, 8'h77, 30);
        show(1, 8'h7C, 30);
        show(2, 8'h39, 30);
        show(3, 8'h49, 30);

        // Remaining decode table entries
        push_exp(16'h9FED, 4'b0000, 4'b0000);
        show(0, 8'h5E, 30);
        show(1, 8'h79, 30);
        show(2, 8'h71, 30);
        show(3, 8'h6F, 30);

        // Reset after three accepts discards the partial frame
        show(0, 8'h3F, 30);
        show(1, 8'h06, 30);
        show(2, 8'h5B, 30);
        rst_n = 1'b0;
        seg   = 8'h00;
        an    = 4'b0000;
        @(posedge clk);
        #1;
        check_zero("midreset");
        rst_n = 1'b1;
        push_exp(16'h6543, 4'b0000, 4'b0000);
        show(0, 8'h4F, 30);
        show(1, 8'h66, 30);
        show(2, 8'h6D, 30);
        check_zero("postreset");
        show(3, 8'h7D, 30);

        seg = 8'h00;
        an  = 4'b0000;
        repeat (5) @(posedge clk);
        #1;
        check("frame_count", nframes, 7);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
